// File: rtl/fb_arbiter_if.sv
// Burst command channel between the frame-buffer arbiter and the SDRAM controller.
// The arbiter drives the command fields; the controller answers with ready and a
// completion pulse for each accepted burst.
interface fb_arbiter_if #(
   parameter int ADDR_W = 24
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [8:0]        cmd_len;
   logic              burst_done;

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_len,
      input  cmd_ready, burst_done
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_len,
      output cmd_ready, burst_done
   );
endinterface

// File: rtl/fb_arbiter.sv
// Frame-buffer burst arbiter: schedules camera write bursts and display read
// bursts to a shared SDRAM, tracks per-frame word pointers and hands completed
// camera frames (ping-pong banks) over to the display path.
module fb_arbiter #(
   parameter int BURST_LEN     = 256,
   parameter int FRAME_WORDS   = 307200,
   parameter int ADDR_W        = 24,
   parameter int FIFO_LW       = 11,
   parameter int RD_FIFO_DEPTH = 1024
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               init_done_i,
   input  logic               wr_frame_start_i,
   input  logic [FIFO_LW-1:0] wr_fifo_level_i,
   input  logic               rd_frame_start_i,
   input  logic [FIFO_LW-1:0] rd_fifo_level_i,
   fb_arbiter_if.master       cmd,
   output logic               wr_bank_o,
   output logic               rd_bank_o,
   output logic               frame_ready_o,
   output logic [7:0]         drop_cnt_o
);

   localparam int PTR_W = ADDR_W - 1;
   localparam logic [PTR_W-1:0]   FRAME_W = PTR_W'(FRAME_WORDS);
   localparam logic [PTR_W-1:0]   BURST_W = PTR_W'(BURST_LEN);
   localparam logic [8:0]         LEN_MAX = 9'(BURST_LEN);
   localparam logic [FIFO_LW:0]   DEPTH_W = (FIFO_LW+1)'(RD_FIFO_DEPTH);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_CMD  = 3'd1;
   localparam logic [2:0] S_WR_WAIT = 3'd2;
   localparam logic [2:0] S_RD_CMD  = 3'd3;
   localparam logic [2:0] S_RD_WAIT = 3'd4;

   logic [2:0]        state_q, state_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic              cmd_write_q, cmd_write_d;
   logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
   logic [8:0]        cmd_len_q, cmd_len_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic              wr_active_q, wr_active_d, rd_active_q, rd_active_d;
   logic              wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
   logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
   logic              done_bank_q, done_bank_d;
   logic              frame_ready_q, frame_ready_d;
   logic [7:0]        drop_cnt_q, drop_cnt_d;
   logic              last_wr_q, last_wr_d;

   logic [PTR_W-1:0]  wr_rem_s, rd_rem_s;
   logic [8:0]        wlen_s, rlen_s;
   logic              wr_elig_s, rd_elig_s;
   logic              wr_busy_s, rd_busy_s, wr_done_s, rd_done_s;
   logic              wr_start_s, rd_start_s;

   assign cmd.cmd_valid = cmd_valid_q;
   assign cmd.cmd_write = cmd_write_q;
   assign cmd.cmd_addr  = cmd_addr_q;
   assign cmd.cmd_len   = cmd_len_q;
   assign wr_bank_o     = wr_bank_q;
   assign rd_bank_o     = rd_bank_q;
   assign frame_ready_o = frame_ready_q;
   assign drop_cnt_o    = drop_cnt_q;

   // Burst lengths and eligibility; a requester whose frame is restarting this
   // cycle is held back so its command never carries a stale pointer.
   always_comb begin
      wr_rem_s  = FRAME_W - wr_ptr_q;
      rd_rem_s  = FRAME_W - rd_ptr_q;
      wlen_s    = (wr_rem_s >= BURST_W) ? LEN_MAX : wr_rem_s[8:0];
      rlen_s    = (rd_rem_s >= BURST_W) ? LEN_MAX : rd_rem_s[8:0];
      wr_elig_s = init_done_i & wr_active_q & (wr_ptr_q < FRAME_W) &
                  (wr_fifo_level_i >= FIFO_LW'(wlen_s)) & ~wr_frame_start_i;
      rd_elig_s = init_done_i & rd_active_q & (rd_ptr_q < FRAME_W) &
                  (({1'b0, rd_fifo_level_i} + (FIFO_LW+1)'(rlen_s)) <= DEPTH_W) &
                  ~rd_frame_start_i;
   end

   // Frame starts: applied at once when the requester is not mid-burst,
   // otherwise held pending until its burst_done.
   always_comb begin
      wr_busy_s  = (state_q == S_WR_CMD) || (state_q == S_WR_WAIT);
      rd_busy_s  = (state_q == S_RD_CMD) || (state_q == S_RD_WAIT);
      wr_done_s  = (state_q == S_WR_WAIT) && cmd.burst_done;
      rd_done_s  = (state_q == S_RD_WAIT) && cmd.burst_done;
      wr_start_s = wr_busy_s ? (wr_done_s & (wr_pend_q | wr_frame_start_i)) : wr_frame_start_i;
      rd_start_s = rd_busy_s ? (rd_done_s & (rd_pend_q | rd_frame_start_i)) : rd_frame_start_i;
      wr_pend_d  = (wr_busy_s && !wr_done_s) ? (wr_pend_q | wr_frame_start_i) : 1'b0;
      rd_pend_d  = (rd_busy_s && !rd_done_s) ? (rd_pend_q | rd_frame_start_i) : 1'b0;
   end

   // Pointer advance, frame completion, then pending/immediate frame start.
   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      wr_active_d   = wr_active_q;
      rd_active_d   = rd_active_q;
      wr_bank_d     = wr_bank_q;
      rd_bank_d     = rd_bank_q;
      done_bank_d   = done_bank_q;
      frame_ready_d = frame_ready_q;
      drop_cnt_d    = drop_cnt_q;
      if (wr_done_s) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(cmd_len_q);
         if (wr_ptr_d == FRAME_W) begin
            frame_ready_d = 1'b1;
            done_bank_d   = wr_bank_q;
            wr_bank_d     = ~wr_bank_q;
            wr_active_d   = 1'b0;
         end else begin
            wr_active_d   = wr_active_q;
         end
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (wr_start_s) begin
         if (wr_active_d && (wr_ptr_d < FRAME_W)) begin
            drop_cnt_d = (drop_cnt_q == 8'hFF) ? 8'hFF : drop_cnt_q + 8'd1;
         end else begin
            drop_cnt_d = drop_cnt_q;
         end
         wr_ptr_d    = '0;
         wr_active_d = 1'b1;
      end else begin
         wr_active_d = wr_active_d;
      end
      if (rd_done_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(cmd_len_q);
         if (rd_ptr_d == FRAME_W) begin
            rd_active_d = 1'b0;
         end else begin
            rd_active_d = rd_active_q;
         end
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      if (rd_start_s && frame_ready_d) begin
         rd_bank_d   = done_bank_d;
         rd_ptr_d    = '0;
         rd_active_d = 1'b1;
      end else begin
         rd_bank_d   = rd_bank_q;
      end
   end

   // Command FSM: round-robin grant in IDLE, hold until accepted, wait for completion.
   always_comb begin
      state_d     = state_q;
      cmd_valid_d = cmd_valid_q;
      cmd_write_d = cmd_write_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_len_d   = cmd_len_q;
      last_wr_d   = last_wr_q;
      case (state_q)
         S_IDLE: begin
            if (wr_elig_s && (!rd_elig_s || !last_wr_q)) begin
               state_d     = S_WR_CMD;
               cmd_valid_d = 1'b1;
               cmd_write_d = 1'b1;
               cmd_addr_d  = {wr_bank_q, wr_ptr_q};
               cmd_len_d   = wlen_s;
               last_wr_d   = 1'b1;
            end else if (rd_elig_s) begin
               state_d     = S_RD_CMD;
               cmd_valid_d = 1'b1;
               cmd_write_d = 1'b0;
               cmd_addr_d  = {rd_bank_q, rd_ptr_q};
               cmd_len_d   = rlen_s;
               last_wr_d   = 1'b0;
            end else begin
               state_d     = S_IDLE;
            end
         end
         S_WR_CMD, S_RD_CMD: begin
            if (cmd.cmd_ready) begin
               state_d     = (state_q == S_WR_CMD) ? S_WR_WAIT : S_RD_WAIT;
               cmd_valid_d = 1'b0;
            end else begin
               state_d     = state_q;
            end
         end
         S_WR_WAIT, S_RD_WAIT: begin
            if (cmd.burst_done) begin
               state_d = S_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d     = S_IDLE;
            cmd_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         cmd_valid_q   <= 1'b0;
         cmd_write_q   <= 1'b0;
         cmd_addr_q    <= '0;
         cmd_len_q     <= 9'd0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         wr_active_q   <= 1'b0;
         rd_active_q   <= 1'b0;
         wr_pend_q     <= 1'b0;
         rd_pend_q     <= 1'b0;
         wr_bank_q     <= 1'b0;
         rd_bank_q     <= 1'b0;
         done_bank_q   <= 1'b0;
         frame_ready_q <= 1'b0;
         drop_cnt_q    <= 8'd0;
         last_wr_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_valid_q   <= cmd_valid_d;
         cmd_write_q   <= cmd_write_d;
         cmd_addr_q    <= cmd_addr_d;
         cmd_len_q     <= cmd_len_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_active_q   <= wr_active_d;
         rd_active_q   <= rd_active_d;
         wr_pend_q     <= wr_pend_d;
         rd_pend_q     <= rd_pend_d;
         wr_bank_q     <= wr_bank_d;
         rd_bank_q     <= rd_bank_d;
         done_bank_q   <= done_bank_d;
         frame_ready_q <= frame_ready_d;
         drop_cnt_q    <= drop_cnt_d;
         last_wr_q     <= last_wr_d;
      end
   end

endmodule
